// File: rtl/csr_regfile.sv
// AXI4-Lite control/status register file with per-register RW/RO/TRIG behaviour.
// Write and read channels run as independent two-state handshake engines.
module csr_regfile #(
    parameter int                       NREG      = 4,
    parameter int                       DATA_W    = 32,
    parameter int                       ADDR_W    = 2,
    parameter logic [NREG-1:0]          RO_MASK   = '0,
    parameter logic [NREG-1:0]          TRIG_MASK = '0,
    parameter logic [NREG*DATA_W-1:0]   RST_VAL   = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           cbus_awaddr,
    input  logic                        cbus_awvalid,
    output logic                        cbus_awready,
    input  logic [DATA_W-1:0]           cbus_wdata,
    input  logic [DATA_W/8-1:0]         cbus_wstrb,
    input  logic                        cbus_wvalid,
    output logic                        cbus_wready,
    output logic [1:0]                  cbus_bresp,
    output logic                        cbus_bvalid,
    input  logic                        cbus_bready,
    input  logic [ADDR_W-1:0]           cbus_araddr,
    input  logic                        cbus_arvalid,
    output logic                        cbus_arready,
    output logic [DATA_W-1:0]           cbus_rdata,
    output logic [1:0]                  cbus_rresp,
    output logic                        cbus_rvalid,
    input  logic                        cbus_rready,
    output logic [NREG*DATA_W-1:0]      reg_q,
    input  logic [NREG*DATA_W-1:0]      ro_i,
    output logic [NREG-1:0]             wr_pulse
);

    localparam int         STRB_W      = DATA_W / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_e;
    typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} rstate_e;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        for (int b = 0; b < STRB_W; b++) begin
            res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return ({{(32-ADDR_W){1'b0}}, a} < 32'(NREG));
    endfunction

    // Write channel state
    wstate_e                  wstate_q, wstate_d;
    logic                     aw_held_q, aw_held_d;
    logic                     w_held_q, w_held_d;
    logic [ADDR_W-1:0]        awaddr_q, awaddr_d;
    logic [DATA_W-1:0]        wdata_q, wdata_d;
    logic [STRB_W-1:0]        wstrb_q, wstrb_d;
    logic                     awready_q, awready_d;
    logic                     wready_q, wready_d;
    logic                     bvalid_q, bvalid_d;
    logic [1:0]               bresp_q, bresp_d;
    logic [NREG-1:0]          wr_pulse_q, wr_pulse_d;
    logic [NREG*DATA_W-1:0]   regs_q, regs_d;

    // Read channel state
    rstate_e                  rstate_q, rstate_d;
    logic                     arready_q, arready_d;
    logic                     rvalid_q, rvalid_d;
    logic [1:0]               rresp_q, rresp_d;
    logic [DATA_W-1:0]        rdata_q, rdata_d;

    logic                     aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic [ADDR_W-1:0]        cmt_addr_s;
    logic [DATA_W-1:0]        cmt_data_s;
    logic [STRB_W-1:0]        cmt_strb_s;
    logic [DATA_W-1:0]        rd_data_s;

    assign aw_hs_s    = cbus_awvalid && awready_q;
    assign w_hs_s     = cbus_wvalid && wready_q;
    assign ar_hs_s    = cbus_arvalid && arready_q;
    // A beat captured on the commit edge itself bypasses its holding register.
    assign cmt_addr_s = aw_hs_s ? cbus_awaddr : awaddr_q;
    assign cmt_data_s = w_hs_s ? cbus_wdata : wdata_q;
    assign cmt_strb_s = w_hs_s ? cbus_wstrb : wstrb_q;

    // Write FSM: collect AW and W in any order, commit, then hold the response.
    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = aw_hs_s ? cbus_awaddr : awaddr_q;
        wdata_d   = w_hs_s ? cbus_wdata : wdata_q;
        wstrb_d   = w_hs_s ? cbus_wstrb : wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        commit_s  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                aw_held_d = aw_held_q || aw_hs_s;
                w_held_d  = w_held_q || w_hs_s;
                if (aw_held_d && w_held_d) begin
                    commit_s  = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = addr_in_range(cmt_addr_s) ? RESP_OKAY : RESP_SLVERR;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    wstate_d  = W_RESP;
                end else begin
                    awready_d = !aw_held_d;
                    wready_d  = !w_held_d;
                end
            end
            W_RESP: begin
                if (bvalid_q && cbus_bready) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    wstate_d  = W_IDLE;
                end else begin
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                end
            end
            default: begin
                wstate_d  = W_IDLE;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                bvalid_d  = 1'b0;
                bresp_d   = RESP_OKAY;
                awready_d = 1'b0;
                wready_d  = 1'b0;
            end
        endcase
    end

    // Register next state: TRIG regs fall back to reset value unless rewritten.
    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        for (int i = 0; i < NREG; i++) begin
            wr_pulse_d[i] = commit_s && addr_in_range(cmt_addr_s)
                            && (cmt_addr_s == ADDR_W'(i));
            if (wr_pulse_d[i] && !RO_MASK[i]) begin
                regs_d[i*DATA_W +: DATA_W] = merge_bytes(regs_q[i*DATA_W +: DATA_W],
                                                         cmt_data_s, cmt_strb_s);
            end else begin
                regs_d[i*DATA_W +: DATA_W] = TRIG_MASK[i] ? RST_VAL[i*DATA_W +: DATA_W]
                                                          : regs_q[i*DATA_W +: DATA_W];
            end
        end
    end

    // Write channel and register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q   <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            regs_q     <= RST_VAL;
        end else begin
            wstate_q   <= wstate_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    // Read mux over current storage, so a same-edge write is not yet visible.
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i < NREG; i++) begin
            if (cbus_araddr == ADDR_W'(i)) begin
                rd_data_s = RO_MASK[i] ? ro_i[i*DATA_W +: DATA_W] : regs_q[i*DATA_W +: DATA_W];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
    end

    // Read FSM: accept one address, then hold data until it is taken.
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = addr_in_range(cbus_araddr) ? rd_data_s : '0;
                    rresp_d   = addr_in_range(cbus_araddr) ? RESP_OKAY : RESP_SLVERR;
                    rstate_d  = R_RESP;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_RESP: begin
                if (rvalid_q && cbus_rready) begin
                    rvalid_d  = 1'b0;
                    rresp_d   = RESP_OKAY;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end else begin
                    arready_d = 1'b0;
                end
            end
            default: begin
                rstate_d  = R_IDLE;
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
                rresp_d   = RESP_OKAY;
                rdata_d   = '0;
            end
        endcase
    end

    // Read channel registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign cbus_awready = awready_q;
    assign cbus_wready  = wready_q;
    assign cbus_bvalid  = bvalid_q;
    assign cbus_bresp   = bresp_q;
    assign cbus_arready = arready_q;
    assign cbus_rvalid  = rvalid_q;
    assign cbus_rresp   = rresp_q;
    assign cbus_rdata   = rdata_q;
    assign reg_q        = regs_q;
    assign wr_pulse     = wr_pulse_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed plus randomized bench for csr_regfile against a word/byte-level register model.
module tb_csr_regfile;

    localparam int NREG = 3;
    localparam int DW   = 32;
    localparam int AW   = 2;
    localparam int SW   = DW / 8;
    localparam logic [NREG-1:0]      RO_M   = 3'b100;
    localparam logic [NREG-1:0]      TRIG_M = 3'b001;
    localparam logic [NREG*DW-1:0]   RSTV   = {32'hCAFE_0002, 32'h1234_5678, 32'h0000_0000};

    typedef logic [NREG*DW-1:0] cv_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [AW-1:0]     awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [DW-1:0]     wdata = '0;
    logic [SW-1:0]     wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [AW-1:0]     araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [NREG*DW-1:0] regq;
    logic [NREG*DW-1:0] ro_in = '0;
    logic [NREG-1:0]   wr_pulse;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mdl [NREG];
    logic [1:0]    exp_bresp;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_rresp;

    csr_regfile #(
        .NREG(NREG), .DATA_W(DW), .ADDR_W(AW),
        .RO_MASK(RO_M), .TRIG_MASK(TRIG_M), .RST_VAL(RSTV)
    ) dut (
        .clk(clk), .rst(rst),
        .cbus_awaddr(awaddr), .cbus_awvalid(awvalid), .cbus_awready(awready),
        .cbus_wdata(wdata), .cbus_wstrb(wstrb), .cbus_wvalid(wvalid), .cbus_wready(wready),
        .cbus_bresp(bresp), .cbus_bvalid(bvalid), .cbus_bready(bready),
        .cbus_araddr(araddr), .cbus_arvalid(arvalid), .cbus_arready(arready),
        .cbus_rdata(rdata), .cbus_rresp(rresp), .cbus_rvalid(rvalid), .cbus_rready(rready),
        .reg_q(regq), .ro_i(ro_in), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input cv_t obs, input cv_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rst_of(input int i);
        cv_t v;
        v = RSTV;
        return v[i*DW +: DW];
    endfunction

    function automatic cv_t model_vec();
        cv_t v;
        for (int i = 0; i < NREG; i++) v[i*DW +: DW] = mdl[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mdl[i] = rst_of(i);
    endtask

    // Issue AW and W with independent delays; return at the cycle bvalid must appear.
    task automatic write_issue(input int a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                               input int aw_dly, input int w_dly);
        int cyc;
        bit aw_done, w_done, aw_hit, w_hit;
        logic [NREG-1:0] exp_pulse;
        logic [DW-1:0] mask;
        cyc = 0; aw_done = 0; w_done = 0;
        exp_pulse = '0;
        if (a >= NREG) begin
            exp_bresp = 2'b10;
        end else begin
            exp_bresp = 2'b00;
            exp_pulse[a] = 1'b1;
            if (!RO_M[a]) begin
                for (int b = 0; b < SW; b++) begin
                    mask = 32'hFF << (8 * b);
                    if (s[b]) mdl[a] = (mdl[a] & ~mask) | (d & mask);
                end
            end
        end
        while (!(aw_done && w_done) && cyc < 60) begin
            chk("bvalid_before_commit", cv_t'(bvalid), cv_t'(0));
            if (!aw_done && cyc >= aw_dly) begin awvalid = 1'b1; awaddr = AW'(a); end
            if (!w_done && cyc >= w_dly) begin wvalid = 1'b1; wdata = d; wstrb = s; end
            aw_hit = awvalid && awready;
            w_hit  = wvalid && wready;
            @(negedge clk);
            cyc++;
            if (aw_hit) begin aw_done = 1; awvalid = 1'b0; end
            if (w_hit)  begin w_done = 1;  wvalid = 1'b0; end
        end
        chk("write_handshake_timeout", cv_t'(aw_done && w_done), cv_t'(1));
        chk("bvalid_at_commit", cv_t'(bvalid), cv_t'(1));
        chk("bresp", cv_t'(bresp), cv_t'(exp_bresp));
        chk("wr_pulse", cv_t'(wr_pulse), cv_t'(exp_pulse));
        chk("reg_q_after_write", regq, model_vec());
        for (int i = 0; i < NREG; i++) if (TRIG_M[i]) mdl[i] = rst_of(i);
        @(negedge clk);
        chk("wr_pulse_one_cycle", cv_t'(wr_pulse), cv_t'(0));
        chk("reg_q_next_cycle", regq, model_vec());
        chk("awready_in_resp", cv_t'(awready), cv_t'(0));
        chk("wready_in_resp", cv_t'(wready), cv_t'(0));
    endtask

    task automatic write_finish(input int b_dly);
        for (int k = 0; k < b_dly; k++) begin
            chk("bvalid_hold", cv_t'(bvalid), cv_t'(1));
            chk("bresp_hold", cv_t'(bresp), cv_t'(exp_bresp));
            chk("aw_w_ready_hold", cv_t'({awready, wready}), cv_t'(0));
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid_cleared", cv_t'(bvalid), cv_t'(0));
        chk("aw_w_ready_back", cv_t'({awready, wready}), cv_t'(2'b11));
    endtask

    task automatic read_issue(input int a, input int dly);
        int cyc;
        bit hit;
        cyc = 0; hit = 0;
        repeat (dly) @(negedge clk);
        arvalid = 1'b1;
        araddr  = AW'(a);
        while (!hit && cyc < 60) begin
            hit = arvalid && arready;
            if (hit) begin
                if (a >= NREG) begin exp_rdata = '0; exp_rresp = 2'b10; end
                else if (RO_M[a]) begin exp_rdata = ro_in[a*DW +: DW]; exp_rresp = 2'b00; end
                else begin exp_rdata = mdl[a]; exp_rresp = 2'b00; end
            end
            @(negedge clk);
            cyc++;
        end
        arvalid = 1'b0;
        chk("read_handshake_timeout", cv_t'(hit), cv_t'(1));
        chk("rvalid", cv_t'(rvalid), cv_t'(1));
        chk("rdata", cv_t'(rdata), cv_t'(exp_rdata));
        chk("rresp", cv_t'(rresp), cv_t'(exp_rresp));
    endtask

    task automatic read_finish(input int r_dly);
        for (int k = 0; k < r_dly; k++) begin
            ro_in = {$urandom, $urandom, $urandom};
            @(negedge clk);
            chk("rvalid_hold", cv_t'(rvalid), cv_t'(1));
            chk("rdata_hold", cv_t'(rdata), cv_t'(exp_rdata));
            chk("arready_in_resp", cv_t'(arready), cv_t'(0));
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("rvalid_cleared", cv_t'(rvalid), cv_t'(0));
        chk("arready_back", cv_t'(arready), cv_t'(1));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, cv_t'({awready, wready, arready}), cv_t'(0));
        chk({tag, "_valid"}, cv_t'({bvalid, rvalid}), cv_t'(0));
        chk({tag, "_resp"}, cv_t'({bresp, rresp}), cv_t'(0));
        chk({tag, "_rdata"}, cv_t'(rdata), cv_t'(0));
        chk({tag, "_pulse"}, cv_t'(wr_pulse), cv_t'(0));
        chk({tag, "_regs"}, regq, RSTV);
    endtask

    initial begin
        #1 rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: same-cycle AW+W to reg1
        write_issue(1, 32'hDEAD_BEEF, 4'hF, 0, 0);
        chk("t1_reg1", cv_t'(regq[63:32]), cv_t'(32'hDEAD_BEEF));
        write_finish(0);

        // 2: W first, AW three cycles later, partial strobes
        write_issue(1, 32'h1122_3344, 4'hF, 0, 0);
        write_finish(1);
        write_issue(1, 32'hAABB_CCDD, 4'b0101, 3, 0);
        chk("t2_merge", cv_t'(regq[63:32]), cv_t'(32'h11BB_33DD));
        write_finish(0);

        // 3: held write response with a concurrent read
        write_issue(1, 32'h0BAD_F00D, 4'hF, 0, 0);
        read_issue(1, 0);
        read_finish(1);
        write_finish(5);

        // 4: RO register and out-of-range accesses
        ro_in = {32'h0000_005A, 32'h0, 32'h0};
        write_issue(2, 32'h0000_00FF, 4'hF, 0, 0);
        write_finish(0);
        read_issue(2, 0);
        chk("t4_ro_read", cv_t'(rdata), cv_t'(32'h5A));
        read_finish(0);
        read_issue(3, 0);
        read_finish(0);
        write_issue(3, 32'h1234_0000, 4'hF, 0, 1);
        write_finish(0);

        // 5: back-to-back TRIG writes
        write_issue(0, 32'h0000_0001, 4'hF, 0, 0);
        write_finish(0);
        write_issue(0, 32'h0000_0080, 4'h1, 1, 0);
        write_finish(0);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            ro_in = {$urandom, $urandom, $urandom};
            write_issue(int'($urandom_range(0, 3)), $urandom, SW'($urandom_range(0, 15)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            write_finish(int'($urandom_range(0, 3)));
            read_issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            read_finish(int'($urandom_range(0, 3)));
        end

        // 6: reset with both responses pending
        write_issue(1, 32'h5555_AAAA, 4'hF, 0, 0);
        read_issue(1, 0);
        rst = 1'b1;
        #1;
        model_reset();
        check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        write_issue(1, 32'h7777_8888, 4'b0011, 0, 2);
        write_finish(1);
        read_issue(1, 0);
        chk("t6_after_reset", cv_t'(rdata), cv_t'(32'h1234_8888));
        read_finish(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
